vector_result_bus: RTL and testbench
====================================

// Module: vector_result_bus
// PURPOSE
//  Producer side of the vector wakeup protocol. Reservation-station entries hold Operands.src_ref (Rs_ref) and wait for results.
//  This block collects completions from the NUM_UNITS vector units and broadcasts one Rs_ref tag plus destination per cycle.
//  Sits between the unit pipelines and the VRF write port / reservation-station wakeup logic.
// PARAMETERS
//  NUM_UNITS  Vector::NUM_UNITS (5)  number of producing units; index i maps to Unit_id i (MADD=0 .. PERMUTE=4)
// PORTS
//  clk              in   1              single clock
//  reset            in   1              asynchronous, active-high reset
//  unit_valid_i     in   NUM_UNITS      unit i offers a completion
//  unit_ready_o     out  NUM_UNITS      unit i's completion is accepted this cycle
//  unit_entry_i     in   NUM_UNITS x4   RS entry index of the completing op
//  unit_dest_i      in   NUM_UNITS x5   Vrf_index destination
//  unit_wdest_i     in   NUM_UNITS      op writes the destination (Operands.write_dest)
//  bus_stall_i      in   1              consumer cannot take the bus this cycle
//  bus_valid_o      out  1              broadcast valid
//  bus_tag_o        out  $bits(Result_tag)  {Rs_ref ref, Vrf_index dest, logic write_dest}
//  bus_unit_o       out  5              one-hot Vector::Unit of the producer
// BEHAVIOUR
//  - Reset (async): bus_valid_o=0, bus_tag_o=0, bus_unit_o=0 (not VU_UNDEF), rr_ptr=0, all skid entries invalid.
//    unit_ready_o=0 while reset is high.
//  - Output stage is a register. load_en = !bus_valid_o || !bus_stall_i.
//  - While bus_valid_o && bus_stall_i, all bus_* outputs hold stable and no grant is issued.
//  - Arbitration is round-robin over requesters, searching from rr_ptr upward with mod-NUM_UNITS wrap.
//    On a grant to index g with load_en, rr_ptr <= (g==NUM_UNITS-1) ? 0 : g+1. With no grant, rr_ptr holds.
//  - Load: bus_tag_o.ref.unit=Unit_id'(g), .ref.entry=entry[g], .dest=dest[g], .write_dest=wdest[g], bus_unit_o=unit_id_to_unit(g).
//  - load_en with no requester: bus_valid_o <= 0. Tag fields hold their last value (don't-care, not cleared).
//  - At most one grant per cycle. A unit whose valid is held high with a constant payload is granted within NUM_UNITS load cycles.
//  - Reset mid-transfer: a pending broadcast or skid entry is discarded. No completion is replayed.
// CONFIGURATION
//  VECTOR_RESBUS_SKID_EN undefined:
//  - Requesters are unit_valid_i.
//  - unit_ready_o[i] = load_en & grant[i] (combinational; depends on unit_valid_i, never the reverse).
//  - Latency: accept in cycle N -> bus_valid_o in cycle N+1.
//  VECTOR_RESBUS_SKID_EN defined:
//  - Each unit has a 1-entry skid register. unit_ready_o[i] = !skid_valid[i], a function of registers only.
//  - The skid loads on valid&ready. Arbitration is over skid_valid only. A skid entry clears when granted with load_en.
//  - A skid cannot be refilled in the cycle it is drained. Latency N -> N+2. Sustained throughput per unit is 1 per 2 cycles.
//  - Bus-side behaviour is otherwise identical.
// STRUCTURE
//  - Package Vector gains:
//    - typedef struct packed {Rs_ref ref; Vrf_index dest; logic write_dest;} Result_tag
//    - function Unit_id unit_index_to_id(int i)
//  - Sub-module vector_rr_arbiter #(N): inputs req[N], ptr, en. Outputs one-hot grant[N], gidx, next_ptr. Purely combinational.
//    rr_ptr register lives in the parent.
//  - Remaining logic, in the parent: skid array under the macro, output register, load_en.
// TESTING
//  1. Reset, then unit_valid_i=5'b00001, entry=3, dest=7, wdest=1:
//     -> bus_valid_o=1 one cycle later (two with SKID), ref={VU_ID_MADD,4'd3}, dest=7, bus_unit_o=VU_MADD.
//  2. All 5 valid every cycle, no stall:
//     -> grants in order 0,1,2,3,4,0. Exactly one unit_ready_o bit per cycle (no-SKID).
//  3. bus_stall_i=1 for 4 cycles with bus_valid_o=1:
//     -> bus_tag_o unchanged, no unit_ready_o asserted (no-SKID). Next grant resumes from the saved rr_ptr.
//  4. rr_ptr=4, requests from units 1 and 4:
//     -> unit 4 granted, then unit 1. rr_ptr wraps to 0 after the first grant.
//  5. Assert reset while bus_valid_o=1 and unit 2's skid is full:
//     -> bus_valid_o=0 immediately, skid cleared, and that completion never appears on the bus.
//  6. SKID build, unit 3 valid continuously:
//     -> unit_ready_o[3] toggles 1,0,1,0. Bus shows a unit-3 tag every other cycle.

Source files
------------

// File: rtl/vector_result_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vector_result_bus_pkg
//  Brief    : Shared vector-unit types for the result broadcast bus.
//  Revision : 1.0  initial release
// ============================================================================
package vector_result_bus_pkg;

    localparam int VEC_NUM_UNITS = 5;

    typedef enum logic [2:0] {
        VU_ID_MADD    = 3'd0,
        VU_ID_ALU     = 3'd1,
        VU_ID_LDST    = 3'd2,
        VU_ID_REDUCE  = 3'd3,
        VU_ID_PERMUTE = 3'd4
    } Unit_id;

    // One-hot producer encoding; VU_UNDEF is deliberately not the all-zero code.
    typedef enum logic [4:0] {
        VU_MADD    = 5'b00001,
        VU_ALU     = 5'b00010,
        VU_LDST    = 5'b00100,
        VU_REDUCE  = 5'b01000,
        VU_PERMUTE = 5'b10000,
        VU_UNDEF   = 5'b11111
    } Unit;

    typedef logic [3:0] Rs_entry;
    typedef logic [4:0] Vrf_index;

    typedef struct packed {
        Unit_id  unit;
        Rs_entry entry;
    } Rs_ref;

    // The reference field is named rs_ref because "ref" is a reserved word.
    typedef struct packed {
        Rs_ref    rs_ref;
        Vrf_index dest;
        logic     write_dest;
    } Result_tag;

    function automatic Unit_id unit_index_to_id(int i);
        return Unit_id'(i[2:0]);
    endfunction

    function automatic Unit unit_id_to_unit(Unit_id id);
        case (id)
            VU_ID_MADD:    return VU_MADD;
            VU_ID_ALU:     return VU_ALU;
            VU_ID_LDST:    return VU_LDST;
            VU_ID_REDUCE:  return VU_REDUCE;
            VU_ID_PERMUTE: return VU_PERMUTE;
            default:       return VU_UNDEF;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/vector_result_bus_arb.sv
`default_nettype none
// ============================================================================
//  Module   : vector_rr_arbiter
//  Brief    : Combinational round-robin arbiter; pointer register is external.
//  Revision : 1.0  initial release
// ============================================================================
module vector_rr_arbiter #(
    parameter int N  = 5,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    input  logic          en_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] gidx_o,
    output logic [PW-1:0] next_ptr_o
);

    logic          found;
    logic [PW-1:0] idx;

    // First requester at or above ptr_i, wrapping modulo N.
    always_comb begin
        found  = 1'b0;
        gidx_o = '0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr_i) + k) % N);
            if (!found && req_i[idx]) begin
                found  = 1'b1;
                gidx_o = idx;
            end
        end
    end

    always_comb begin
        grant_o    = '0;
        next_ptr_o = ptr_i;
        if (en_i && found) begin
            grant_o[gidx_o] = 1'b1;
            next_ptr_o      = (gidx_o == PW'(N - 1)) ? '0 : gidx_o + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vector_result_bus.sv
`default_nettype none
// ============================================================================
//  Module   : vector_result_bus
//  Brief    : Collects vector-unit completions, broadcasts one wakeup tag per
//             cycle. VECTOR_RESBUS_SKID_EN adds a 1-entry skid per unit.
//  Revision : 1.0  initial release
// ============================================================================
module vector_result_bus
    import vector_result_bus_pkg::*;
#(
    parameter int NUM_UNITS = VEC_NUM_UNITS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_UNITS-1:0]      unit_valid_i,
    output logic [NUM_UNITS-1:0]      unit_ready_o,
    input  logic [NUM_UNITS-1:0][3:0] unit_entry_i,
    input  logic [NUM_UNITS-1:0][4:0] unit_dest_i,
    input  logic [NUM_UNITS-1:0]      unit_wdest_i,
    input  logic                      bus_stall_i,
    output logic                      bus_valid_o,
    output Result_tag                 bus_tag_o,
    output logic [4:0]                bus_unit_o
);

    localparam int PW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic                      load_en;
    logic [NUM_UNITS-1:0]      req;
    logic [NUM_UNITS-1:0]      grant;
    logic [PW-1:0]             gidx;
    logic [PW-1:0]             rr_ptr_q;
    logic [PW-1:0]             rr_ptr_d;
    logic [NUM_UNITS-1:0][3:0] src_entry;
    logic [NUM_UNITS-1:0][4:0] src_dest;
    logic [NUM_UNITS-1:0]      src_wdest;

    logic                      bus_valid_q;
    Result_tag                 bus_tag_q;
    logic [4:0]                bus_unit_q;

    assign load_en = !bus_valid_q || !bus_stall_i;

`ifdef VECTOR_RESBUS_SKID_EN
    logic [NUM_UNITS-1:0]      skid_valid_q;
    logic [NUM_UNITS-1:0]      skid_valid_d;
    logic [NUM_UNITS-1:0][3:0] skid_entry_q;
    logic [NUM_UNITS-1:0][4:0] skid_dest_q;
    logic [NUM_UNITS-1:0]      skid_wdest_q;
    logic                      ready_en_q;

    // ready_en_q keeps ready a pure register function while still low in reset.
    assign unit_ready_o = ~skid_valid_q & {NUM_UNITS{ready_en_q}};
    assign req          = skid_valid_q;
    assign src_entry    = skid_entry_q;
    assign src_dest     = skid_dest_q;
    assign src_wdest    = skid_wdest_q;

    always_comb begin
        skid_valid_d = (skid_valid_q & ~grant) | (unit_valid_i & unit_ready_o);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_valid_q <= '0;
            skid_entry_q <= '0;
            skid_dest_q  <= '0;
            skid_wdest_q <= '0;
            ready_en_q   <= 1'b0;
        end else begin
            skid_valid_q <= skid_valid_d;
            ready_en_q   <= 1'b1;
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (unit_valid_i[i] && unit_ready_o[i]) begin
                    skid_entry_q[i] <= unit_entry_i[i];
                    skid_dest_q[i]  <= unit_dest_i[i];
                    skid_wdest_q[i] <= unit_wdest_i[i];
                end
            end
        end
    end
`else
    assign req          = unit_valid_i;
    assign unit_ready_o = grant & {NUM_UNITS{!reset}};
    assign src_entry    = unit_entry_i;
    assign src_dest     = unit_dest_i;
    assign src_wdest    = unit_wdest_i;
`endif

    vector_rr_arbiter #(
        .N  (NUM_UNITS),
        .PW (PW)
    ) u_arb (
        .req_i      (req),
        .ptr_i      (rr_ptr_q),
        .en_i       (load_en),
        .grant_o    (grant),
        .gidx_o     (gidx),
        .next_ptr_o (rr_ptr_d)
    );

    // Tag fields are left untouched when the bus goes idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_valid_q <= 1'b0;
            bus_tag_q   <= '0;
            bus_unit_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (load_en) begin
                bus_valid_q <= |req;
                if (|req) begin
                    bus_tag_q.rs_ref.unit  <= unit_index_to_id(int'(gidx));
                    bus_tag_q.rs_ref.entry <= src_entry[gidx];
                    bus_tag_q.dest         <= src_dest[gidx];
                    bus_tag_q.write_dest   <= src_wdest[gidx];
                    bus_unit_q             <= unit_id_to_unit(unit_index_to_id(int'(gidx)));
                end
            end
        end
    end

    assign bus_valid_o = bus_valid_q;
    assign bus_tag_o   = bus_tag_q;
    assign bus_unit_o  = bus_unit_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_result_bus.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vector_result_bus
//  Brief    : Directed table-driven bench for vector_result_bus (both builds).
//  Revision : 1.0  initial release
// ============================================================================
module tb_vector_result_bus;
    import vector_result_bus_pkg::*;

    localparam int NU = 5;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NU-1:0]        unit_valid;
    logic [NU-1:0]        unit_ready;
    logic [NU-1:0][3:0]   unit_entry;
    logic [NU-1:0][4:0]   unit_dest;
    logic [NU-1:0]        unit_wdest;
    logic                 bus_stall;
    logic                 bus_valid;
    Result_tag            bus_tag;
    logic [4:0]           bus_unit;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vector_result_bus #(.NUM_UNITS(NU)) dut (
        .clk          (clk),
        .reset        (reset),
        .unit_valid_i (unit_valid),
        .unit_ready_o (unit_ready),
        .unit_entry_i (unit_entry),
        .unit_dest_i  (unit_dest),
        .unit_wdest_i (unit_wdest),
        .bus_stall_i  (bus_stall),
        .bus_valid_o  (bus_valid),
        .bus_tag_o    (bus_tag),
        .bus_unit_o   (bus_unit)
    );

    typedef struct {
        logic [4:0] valid;
        logic       stall;
        logic [4:0] ready;
        logic       bvalid;
        int         idx;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Fixed per-unit payload: entry=3+2i, dest=7+i, write_dest on even units.
    function automatic logic [12:0] exp_tag(int i);
        return {3'(i), 4'(3 + 2 * i), 5'(7 + i), (i % 2 == 0)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        unit_valid = '0;
        bus_stall  = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    vec_t tbl[19];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NU; i++) begin
            unit_entry[i] = 4'(3 + 2 * i);
            unit_dest[i]  = 5'(7 + i);
            unit_wdest[i] = (i % 2 == 0);
        end
        unit_valid = '1;
        bus_stall  = 1'b0;

        tbl[0]  = '{5'b11111, 1'b0, 5'b00001, 1'b1, 0};
        tbl[1]  = '{5'b11111, 1'b0, 5'b00010, 1'b1, 1};
        tbl[2]  = '{5'b11111, 1'b0, 5'b00100, 1'b1, 2};
        tbl[3]  = '{5'b11111, 1'b0, 5'b01000, 1'b1, 3};
        tbl[4]  = '{5'b11111, 1'b0, 5'b10000, 1'b1, 4};
        tbl[5]  = '{5'b11111, 1'b0, 5'b00001, 1'b1, 0};
        tbl[6]  = '{5'b11111, 1'b1, 5'b00000, 1'b1, 0};
        tbl[7]  = '{5'b11111, 1'b1, 5'b00000, 1'b1, 0};
        tbl[8]  = '{5'b11111, 1'b1, 5'b00000, 1'b1, 0};
        tbl[9]  = '{5'b11111, 1'b1, 5'b00000, 1'b1, 0};
        tbl[10] = '{5'b11111, 1'b0, 5'b00010, 1'b1, 1};
        tbl[11] = '{5'b00000, 1'b0, 5'b00000, 1'b0, 0};
        tbl[12] = '{5'b00000, 1'b1, 5'b00000, 1'b0, 0};
        tbl[13] = '{5'b00100, 1'b1, 5'b00100, 1'b1, 2};
        tbl[14] = '{5'b01000, 1'b0, 5'b01000, 1'b1, 3};
        tbl[15] = '{5'b10010, 1'b0, 5'b10000, 1'b1, 4};
        tbl[16] = '{5'b10010, 1'b0, 5'b00010, 1'b1, 1};
        tbl[17] = '{5'b00001, 1'b1, 5'b00000, 1'b1, 1};
        tbl[18] = '{5'b00001, 1'b0, 5'b00001, 1'b1, 0};

        // Reset state, with every unit requesting.
        step();
        chk("reset ready", 32'(unit_ready), 32'd0);
        chk("reset bus_valid", 32'(bus_valid), 32'd0);
        chk("reset bus_tag", 32'(bus_tag), 32'd0);
        chk("reset bus_unit", 32'(bus_unit), 32'd0);
        unit_valid = '0;
        reset      = 1'b0;
        step();

`ifndef VECTOR_RESBUS_SKID_EN
        for (int r = 0; r < 19; r++) begin
            unit_valid = tbl[r].valid;
            bus_stall  = tbl[r].stall;
            #2;
            chk($sformatf("row%0d ready", r), 32'(unit_ready), 32'(tbl[r].ready));
            step();
            chk($sformatf("row%0d bus_valid", r), 32'(bus_valid), 32'(tbl[r].bvalid));
            if (tbl[r].bvalid) begin
                chk($sformatf("row%0d bus_tag", r), 32'(bus_tag), 32'(exp_tag(tbl[r].idx)));
                chk($sformatf("row%0d bus_unit", r), 32'(bus_unit), 32'(5'b00001 << tbl[r].idx));
            end
        end
`endif

        // Single MADD completion and its latency.
        do_reset();
        unit_valid = 5'b00001;
        #2;
        chk("lat ready0", 32'(unit_ready[0]), 32'd1);
        step();
        unit_valid = '0;
`ifdef VECTOR_RESBUS_SKID_EN
        chk("lat bus_valid early", 32'(bus_valid), 32'd0);
        step();
`endif
        chk("lat bus_valid", 32'(bus_valid), 32'd1);
        chk("lat bus_tag", 32'(bus_tag), 32'(13'b000_0011_00111_1));
        chk("lat bus_unit", 32'(bus_unit), 32'(5'b00001));

        // Reset asserted while a broadcast is pending.
        do_reset();
`ifdef VECTOR_RESBUS_SKID_EN
        unit_valid = 5'b00001;
        step();
        unit_valid = 5'b00100;
        bus_stall  = 1'b1;
        step();
        chk("midrst bus_valid pre", 32'(bus_valid), 32'd1);
        chk("midrst ready pre", 32'(unit_ready), 32'(5'b11011));
        unit_valid = '0;
`else
        unit_valid = 5'b00100;
        bus_stall  = 1'b1;
        step();
        chk("midrst bus_valid pre", 32'(bus_valid), 32'd1);
        chk("midrst bus_unit pre", 32'(bus_unit), 32'(5'b00100));
`endif
        #2;
        reset = 1'b1;
        #1;
        chk("midrst bus_valid", 32'(bus_valid), 32'd0);
        chk("midrst bus_tag", 32'(bus_tag), 32'd0);
        chk("midrst bus_unit", 32'(bus_unit), 32'd0);
        chk("midrst ready", 32'(unit_ready), 32'd0);
        unit_valid = '0;
        bus_stall  = 1'b0;
        step();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("midrst replay c%0d", k), 32'(bus_valid), 32'd0);
        end

`ifdef VECTOR_RESBUS_SKID_EN
        // Continuous unit-3 traffic through its skid: one accept per two cycles.
        do_reset();
        unit_valid = 5'b01000;
        for (int k = 0; k < 8; k++) begin
            #2;
            chk($sformatf("skid ready3 c%0d", k), 32'(unit_ready[3]), 32'(k % 2 == 0));
            chk($sformatf("skid bus_valid c%0d", k), 32'(bus_valid), 32'(k >= 2 && k % 2 == 0));
            if (k >= 2 && k % 2 == 0) begin
                chk($sformatf("skid bus_unit c%0d", k), 32'(bus_unit), 32'(5'b01000));
            end
            step();
        end
        unit_valid = '0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
